// File: rtl/uart_rx_frame.sv
// UART receiver with run-time data length, parity and stop-bit selection.
// Mid-bit sampling on an oversampling tick; received words queue in a small FWFT FIFO.
module uart_rx_frame #(
    parameter int NB_DATA    = 8,
    parameter int OVS        = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s_tick,
    input  logic               rx,
    input  logic [3:0]         cfg_nbits,
    input  logic               cfg_parity_en,
    input  logic               cfg_parity_odd,
    input  logic               cfg_stop2,
    input  logic               rd_en,
    output logic               rx_valid,
    output logic [NB_DATA-1:0] rx_data,
    output logic               rx_parity_err,
    output logic               rx_frame_err,
    output logic               overrun_tick,
    output logic               busy
);
    localparam int TW = $clog2(OVS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int WW = NB_DATA + 2;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t             state_reg, state_next;
    logic [TW-1:0]      tick_reg, tick_next;
    logic [3:0]         bit_reg, bit_next;
    logic               stop_reg, stop_next;
    logic [NB_DATA-1:0] data_reg, data_next;
    logic               perr_reg, perr_next;
    logic               ferr_reg, ferr_next;
    logic [3:0]         nbits_reg, nbits_next;
    logic               par_en_reg, par_en_next;
    logic               par_odd_reg, par_odd_next;
    logic               stop2_reg, stop2_next;
    logic               rx_meta_reg, rx_s_reg;
    logic               sample, push;
    logic [WW-1:0]      push_word;
    logic [3:0]         nbits_eff;
    logic [TW-1:0]      tick_term;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_s_reg    <= rx_meta_reg;
        end
    end

    assign nbits_eff = (cfg_nbits >= 4'd5 && cfg_nbits <= 4'(NB_DATA)) ? cfg_nbits : 4'(NB_DATA);
    assign tick_term = (state_reg == START) ? TW'(OVS / 2 - 1) : TW'(OVS - 1);
    assign sample    = s_tick && (tick_reg == tick_term);
    assign busy      = (state_reg != IDLE);

    always_comb begin
        state_next   = state_reg;
        tick_next    = tick_reg;
        bit_next     = bit_reg;
        stop_next    = stop_reg;
        data_next    = data_reg;
        perr_next    = perr_reg;
        ferr_next    = ferr_reg;
        nbits_next   = nbits_reg;
        par_en_next  = par_en_reg;
        par_odd_next = par_odd_reg;
        stop2_next   = stop2_reg;
        push         = 1'b0;
        push_word    = {ferr_reg | ~rx_s_reg, perr_reg, data_reg};
        if (state_reg != IDLE && s_tick)
            tick_next = sample ? '0 : tick_reg + TW'(1);
        case (state_reg)
            IDLE: begin
                if (!rx_s_reg) begin
                    state_next   = START;
                    tick_next    = '0;
                    nbits_next   = nbits_eff;
                    par_en_next  = cfg_parity_en;
                    par_odd_next = cfg_parity_odd;
                    stop2_next   = cfg_stop2;
                    data_next    = '0;
                    perr_next    = 1'b0;
                    ferr_next    = 1'b0;
                end
            end
            START: begin
                if (sample) begin
                    state_next = rx_s_reg ? IDLE : DATA;
                    bit_next   = '0;
                end
            end
            DATA: begin
                if (sample) begin
                    data_next = data_reg | (NB_DATA'(rx_s_reg) << bit_reg);
                    bit_next  = bit_reg + 4'd1;
                    if (bit_reg == nbits_reg - 4'd1) begin
                        state_next = par_en_reg ? PARITY : STOP;
                        stop_next  = 1'b0;
                    end
                end
            end
            PARITY: begin
                if (sample) begin
                    // data_reg upper bits are zero, so a full-width reduction is safe
                    perr_next  = (^data_reg) ^ rx_s_reg ^ par_odd_reg;
                    state_next = STOP;
                    stop_next  = 1'b0;
                end
            end
            STOP: begin
                if (sample) begin
                    if (!rx_s_reg) ferr_next = 1'b1;
                    if (stop2_reg && !stop_reg) begin
                        stop_next = 1'b1;
                    end else begin
                        push       = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            tick_reg    <= '0;
            bit_reg     <= '0;
            stop_reg    <= 1'b0;
            data_reg    <= '0;
            perr_reg    <= 1'b0;
            ferr_reg    <= 1'b0;
            nbits_reg   <= '0;
            par_en_reg  <= 1'b0;
            par_odd_reg <= 1'b0;
            stop2_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            tick_reg    <= tick_next;
            bit_reg     <= bit_next;
            stop_reg    <= stop_next;
            data_reg    <= data_next;
            perr_reg    <= perr_next;
            ferr_reg    <= ferr_next;
            nbits_reg   <= nbits_next;
            par_en_reg  <= par_en_next;
            par_odd_reg <= par_odd_next;
            stop2_reg   <= stop2_next;
        end
    end

    logic [WW-1:0]         mem_reg [FIFO_DEPTH];
    logic [WW-1:0]         last_reg, head_word, out_word;
    logic [PW-1:0]         wr_ptr_reg, rd_ptr_reg;
    logic [PW:0]           cnt_reg;
    logic [FIFO_DEPTH-1:0] wr_sel;
    logic                  pop, full, do_push, overrun_reg;

    assign rx_valid = (cnt_reg != '0);
    assign full     = (cnt_reg == (PW + 1)'(FIFO_DEPTH));
    assign pop      = rd_en && rx_valid;
    assign do_push  = push && (!full || pop);

    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_wr_sel
        assign wr_sel[gi] = do_push && (wr_ptr_reg == PW'(gi));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_reg[i] <= '0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            cnt_reg     <= '0;
            last_reg    <= '0;
            overrun_reg <= 1'b0;
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                if (wr_sel[i]) mem_reg[i] <= push_word;
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)     rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({do_push, pop})
                2'b10:   cnt_reg <= cnt_reg + (PW + 1)'(1);
                2'b01:   cnt_reg <= cnt_reg - (PW + 1)'(1);
                default: cnt_reg <= cnt_reg;
            endcase
            // keeps the outputs stable once the last word has been popped
            if (rx_valid) last_reg <= head_word;
            overrun_reg <= push && full && !pop;
        end
    end

    assign head_word     = mem_reg[rd_ptr_reg];
    assign out_word      = rx_valid ? head_word : last_reg;
    assign rx_data       = out_word[NB_DATA-1:0];
    assign rx_parity_err = out_word[NB_DATA];
    assign rx_frame_err  = out_word[NB_DATA+1];
    assign overrun_tick  = overrun_reg;
endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: table of single-frame configurations plus
// hand-written false-start, overrun, pop-on-push and mid-frame reset sequences.
module tb_uart_rx_frame;
    logic       clk = 1'b0;
    logic       reset, s_tick, rx, rd_en;
    logic [3:0] cfg_nbits;
    logic       cfg_parity_en, cfg_parity_odd, cfg_stop2;
    logic       rx_valid, rx_parity_err, rx_frame_err, overrun_tick, busy;
    logic [7:0] rx_data;

    int n_tests = 0;
    int n_fail  = 0;
    int ovr_cnt = 0;

    uart_rx_frame #(.NB_DATA(8), .OVS(16), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx),
        .cfg_nbits(cfg_nbits), .cfg_parity_en(cfg_parity_en),
        .cfg_parity_odd(cfg_parity_odd), .cfg_stop2(cfg_stop2),
        .rd_en(rd_en), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
        .overrun_tick(overrun_tick), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (overrun_tick === 1'b1) ovr_cnt++;

    typedef struct {
        logic [7:0] data;
        logic [3:0] cfg_nbits;
        int         line_bits;
        logic       par_en, par_odd, par_bit, stop2, stop_low;
        logic [7:0] exp_data;
        logic       exp_perr, exp_ferr;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // s_tick is held high, so one bit period is 16 clk; called on a negedge
    task automatic drive_bit(input logic b, input int n);
        rx = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb, input logic pe,
                              input logic pb, input logic s2, input logic slow);
        drive_bit(1'b0, 16);
        for (int i = 0; i < nb; i++) drive_bit(d[i], 16);
        if (pe) drive_bit(pb, 16);
        if (s2) drive_bit(1'b1, 16);
        if (slow) begin
            drive_bit(1'b0, 12);
            drive_bit(1'b1, 4);
        end else begin
            drive_bit(1'b1, 16);
        end
    endtask

    task automatic pop_check(input string name, input logic [7:0] exp);
        check({name, "_valid"}, 32'(rx_valid), 32'd1);
        check({name, "_data"}, 32'(rx_data), 32'(exp));
        $display("[TB] pop %s data=0x%02h", name, rx_data);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic set_8n1();
        cfg_nbits = 4'd8; cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0; cfg_stop2 = 1'b0;
    endtask

    initial begin
        //         data   cfg   bits pe   odd  pbit s2   slow  exp    perr ferr
        vecs[0]  = '{8'hA5, 4'd8,  8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
        vecs[1]  = '{8'h41, 4'd7,  7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h41, 1'b1, 1'b0};
        vecs[2]  = '{8'h41, 4'd7,  7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0};
        vecs[3]  = '{8'h41, 4'd7,  7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0};
        vecs[4]  = '{8'h3C, 4'd8,  8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1};
        vecs[5]  = '{8'hF5, 4'd5,  5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h15, 1'b0, 1'b0};
        vecs[6]  = '{8'hFF, 4'd8,  8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[7]  = '{8'h00, 4'd8,  8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[8]  = '{8'hC3, 4'd12, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b0};
        vecs[9]  = '{8'h96, 4'd0,  8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h96, 1'b0, 1'b0};
        vecs[10] = '{8'h1F, 4'd5,  5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h1F, 1'b0, 1'b0};
        vecs[11] = '{8'h80, 4'd8,  8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h80, 1'b0, 1'b0};

        reset = 1'b1; rx = 1'b1; rd_en = 1'b0; s_tick = 1'b1;
        set_8n1();
        repeat (3) @(negedge clk);
        check("reset_valid", 32'(rx_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_data", 32'(rx_data), 32'd0);
        check("reset_flags", 32'({rx_parity_err, rx_frame_err, overrun_tick}), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            cfg_nbits      = vecs[i].cfg_nbits;
            cfg_parity_en  = vecs[i].par_en;
            cfg_parity_odd = vecs[i].par_odd;
            cfg_stop2      = vecs[i].stop2;
            send_frame(vecs[i].data, vecs[i].line_bits, vecs[i].par_en,
                       vecs[i].par_bit, vecs[i].stop2, vecs[i].stop_low);
            check($sformatf("v%0d_valid", i), 32'(rx_valid), 32'd1);
            check($sformatf("v%0d_data", i), 32'(rx_data), 32'(vecs[i].exp_data));
            check($sformatf("v%0d_perr", i), 32'(rx_parity_err), 32'(vecs[i].exp_perr));
            check($sformatf("v%0d_ferr", i), 32'(rx_frame_err), 32'(vecs[i].exp_ferr));
            $display("[TB] vec %0d data=0x%02h perr=%0d ferr=%0d", i, rx_data, rx_parity_err, rx_frame_err);
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
            check($sformatf("v%0d_empty", i), 32'(rx_valid), 32'd0);
            drive_bit(1'b1, 16);
        end

        // false start: line low for 4 ticks only
        set_8n1();
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 2);
        check("fs_busy", 32'(busy), 32'd1);
        drive_bit(1'b1, 20);
        check("fs_idle", 32'(busy), 32'd0);
        check("fs_valid", 32'(rx_valid), 32'd0);
        $display("[TB] false start busy=%0d valid=%0d", busy, rx_valid);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        // cfg changes mid-frame must not affect the frame in flight
        fork
            send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b0);
            begin
                repeat (40) @(negedge clk);
                cfg_nbits = 4'd5; cfg_parity_en = 1'b1; cfg_stop2 = 1'b1;
            end
        join
        set_8n1();
        check("fs_5a_perr", 32'(rx_parity_err), 32'd0);
        pop_check("fs_5a", 8'h5A);
        check("fs_5a_empty", 32'(rx_valid), 32'd0);
        drive_bit(1'b1, 16);

        // overrun: five back-to-back frames without reads
        ovr_cnt = 0;
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 8, 1'b0, 1'b0, 1'b0, 1'b0);
        check("ovr_none_at4", 32'(ovr_cnt), 32'd0);
        send_frame(8'h05, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        check("ovr_once", 32'(ovr_cnt), 32'd1);
        for (int i = 1; i <= 4; i++) pop_check($sformatf("ovr_rd%0d", i), 8'(i));
        check("ovr_drained", 32'(rx_valid), 32'd0);
        check("ovr_hold", 32'(rx_data), 32'h04);

        // refill, then pop on the exact edge that pushes the fifth word (posedge 155 of the frame)
        for (int i = 1; i <= 4; i++) send_frame(8'(8'h10 + i), 8, 1'b0, 1'b0, 1'b0, 1'b0);
        fork
            send_frame(8'h15, 8, 1'b0, 1'b0, 1'b0, 1'b0);
            begin
                repeat (154) @(posedge clk);
                @(negedge clk);
                rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
            end
        join
        check("pp_no_ovr", 32'(ovr_cnt), 32'd1);
        for (int i = 2; i <= 5; i++) pop_check($sformatf("pp_rd%0d", i), 8'(8'h10 + i));
        check("pp_drained", 32'(rx_valid), 32'd0);

        // asynchronous reset in the middle of the data bits of 0x77
        drive_bit(1'b1, 16);
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 16);
        drive_bit(1'b1, 8);
        check("rst_pre_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_data", 32'(rx_data), 32'd0);
        $display("[TB] mid-frame reset busy=%0d valid=%0d data=0x%02h", busy, rx_valid, rx_data);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        drive_bit(1'b1, 32);
        check("rst_nothing_pushed", 32'(rx_valid), 32'd0);
        send_frame(8'h88, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_88_flags", 32'({rx_parity_err, rx_frame_err}), 32'd0);
        pop_check("rst_88", 8'h88);
        check("rst_88_empty", 32'(rx_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
